chip8_fb_renderer: RTL and testbench
====================================

Name: chip8_fb_renderer

Overview:
- Copies the 64x32 monochrome CHIP-8 display area from main RAM into the 128x64 LCD framebuffer RAM read by the LCD12864 controller.
- Each CHIP-8 pixel is scaled 2x2.
- Sits between the CPU's main RAM (read port) and the framebuffer RAM (write port).
- Triggered once per frame by the top-level timer pulse `renderer_start`.

Parameters:
- SRC_BASE, 12'hF00, main RAM address of CHIP-8 display byte 0. 256 bytes, row-major, 8 bytes per row, MSB = leftmost pixel.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start_signal  input  1  one-cycle request to render a full frame
- main_ram_read_address  output  12  main RAM read address
- main_ram_out  input  8  main RAM read data; registered RAM, valid the cycle after the address is presented
- fb_write_address  output  10  framebuffer write address
- fb_write_enable  output  1  framebuffer write strobe, one write per cycle
- fb_ram_in  output  8  framebuffer write data
- busy  output  1  high while rendering; top level uses it to mux the main RAM read address away from the CPU
- finished_signal  output  1  one-cycle pulse when the frame is complete

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset=0 at a clock edge forces state IDLE, src_idx=0, and all outputs to reset values.
  - Reset values: busy=0, finished_signal=0, fb_write_enable=0, fb_write_address=0, fb_ram_in=0, main_ram_read_address=SRC_BASE.
- State machine: IDLE, ADDR, WAIT, W0, W1, W2, W3.
  - src_idx is an 8-bit counter; y=src_idx[7:3], x=src_idx[2:0].
- IDLE:
  - start_signal=1 sampled at an edge: src_idx<=0, main_ram_read_address<=SRC_BASE, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR: main_ram_read_address=SRC_BASE+src_idx (12-bit wrap); go to WAIT.
- WAIT: main_ram_out is valid; capture it into pix at the end of the cycle; go to W0.
- Horizontal expansion:
  - hi = {p7,p7,p6,p6,p5,p5,p4,p4}
  - lo = {p3,p3,p2,p2,p1,p1,p0,p0}
- Framebuffer layout: 16 bytes per row, 64 rows, MSB = leftmost pixel. fb_write_address = {y, k, x, j}, where k = duplicated row and j = byte half.
- Write states, each one cycle with fb_write_enable=1:
  - W0: k=0, j=0, data hi
  - W1: k=0, j=1, data lo
  - W2: k=1, j=0, data hi
  - W3: k=1, j=1, data lo
  - fb_write_enable=0 in every other state.
- After W3:
  - If src_idx != 255: src_idx++, go to ADDR.
  - Else go to IDLE and assert finished_signal for exactly that first IDLE cycle.
- Latency:
  - Start sampled at edge t0; active cycles 1..1536 (6 cycles x 256 bytes); busy=1 exactly in those cycles.
  - finished_signal=1 in cycle 1537.
- start_signal handling:
  - start_signal while busy is ignored and not queued.
  - start_signal in the cycle finished_signal=1 (FSM in IDLE) is accepted; the new frame begins.
- Reset mid-frame: abort immediately. No further writes and no finished_signal. Framebuffer contents are left partial.
- Output registers: fb_* and main_ram_read_address are registered, or decoded directly from state registers; no combinational path from main_ram_out to fb_ram_in.
- Frame consistency: the renderer does not enforce it; CPU writes to the display area during a render may tear.

Decomposition:
- Shared package chip8_pkg:
  - CHIP8_DISP_BASE (12'hF00), DISP_BYTES (256), FB_ROW_BYTES (16).
  - State encoding localparams for IDLE/ADDR/WAIT/W0..W3.
- Sub-module pixel_doubler: combinational 8-bit to 16-bit bit-duplication (hi/lo). Shared with the future VGA path.

Test Plan:
- All display bytes 0x00, one start pulse:
  - Exactly 1024 writes, all data 0x00, covering every address 0x000..0x3FF once.
  - finished_signal at cycle 1537; busy high for 1536 cycles.
- Byte idx0=0x80, rest 0:
  - fb[0x000]=0xC0, fb[0x010]=0xC0, fb[0x001]=0x00, fb[0x011]=0x00.
  - main_ram_read_address=0xF00 during the first ADDR.
- Byte idx255=0x01:
  - fb[0x3EE]=0x00, fb[0x3EF]=0x03, fb[0x3FE]=0x00, fb[0x3FF]=0x03.
  - Read address 0xFFF.
- Byte idx9=0xA5 (y=1, x=1):
  - Writes in order 0x022=0xCC, 0x023=0x33, 0x032=0xCC, 0x033=0x33, on four consecutive cycles starting 2 cycles after the ADDR cycle.
- start_signal re-pulsed at cycle 500:
  - Ignored; exactly one finished_signal.
  - Second start in the finished_signal cycle: new frame starts the next cycle, 1024 more writes.
- reset=0 at cycle 700, then released:
  - From the next cycle: busy=0, fb_write_enable=0, no finished_signal, main_ram_read_address=0xF00.
  - A subsequent start renders a full frame.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants, renderer state encoding and the
// pixel bit-duplication helper.
package chip8_pkg;

    localparam logic [11:0] CHIP8_DISP_BASE = 12'hF00;
    localparam int          DISP_BYTES      = 256;
    localparam int          FB_ROW_BYTES    = 16;
    localparam logic [7:0]  LAST_DISP_IDX   = 8'(DISP_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_W0   = 3'd3,
        ST_W1   = 3'd4,
        ST_W2   = 3'd5,
        ST_W3   = 3'd6
    } render_state_t;

    // Each source bit becomes two adjacent destination bits, MSB stays leftmost.
    function automatic logic [15:0] double_bits(input logic [7:0] b);
        logic [15:0] d;
        d = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            d[2*i]   = b[i];
            d[2*i+1] = b[i];
        end
        return d;
    endfunction

endpackage

// File: rtl/chip8_fb_renderer_pixel_doubler.sv
// Combinational 8-pixel to 16-pixel horizontal expansion, split into the
// left (hi) and right (lo) framebuffer bytes.
module pixel_doubler
    import chip8_pkg::*;
(
    input  logic [7:0] pix,
    output logic [7:0] hi,
    output logic [7:0] lo
);

    assign {hi, lo} = double_bits(pix);

endmodule

// File: rtl/chip8_fb_renderer.sv
// Copies the 64x32 CHIP-8 display from main RAM into the 128x64 LCD
// framebuffer, scaling every pixel 2x2. One frame per start_signal.
module chip8_fb_renderer
    import chip8_pkg::*;
#(
    parameter logic [11:0] SRC_BASE = CHIP8_DISP_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_signal,
    output logic [11:0] main_ram_read_address,
    input  logic [7:0]  main_ram_out,
    output logic [9:0]  fb_write_address,
    output logic        fb_write_enable,
    output logic [7:0]  fb_ram_in,
    output logic        busy,
    output logic        finished_signal
);

    render_state_t state_r;
    render_state_t state_s;
    logic [7:0]    src_idx_r;
    logic [7:0]    pix_r;
    logic [11:0]   rd_addr_r;
    logic          finished_r;
    logic [7:0]    hi_s;
    logic [7:0]    lo_s;
    logic [4:0]    y_s;
    logic [2:0]    x_s;
    logic          last_s;

    assign y_s    = src_idx_r[7:3];
    assign x_s    = src_idx_r[2:0];
    assign last_s = (src_idx_r == LAST_DISP_IDX);

    pixel_doubler u_doubler (
        .pix (pix_r),
        .hi  (hi_s),
        .lo  (lo_s)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: six cycles per source byte.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start_signal) begin
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: state_s = ST_WAIT;
            ST_WAIT: state_s = ST_W0;
            ST_W0:   state_s = ST_W1;
            ST_W1:   state_s = ST_W2;
            ST_W2:   state_s = ST_W3;
            ST_W3: begin
                if (last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: byte index, read address (valid on entry to ADDR), pixel
    // capture and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            src_idx_r  <= 8'd0;
            pix_r      <= 8'd0;
            rd_addr_r  <= SRC_BASE;
            finished_r <= 1'b0;
        end else begin
            finished_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_signal) begin
                        src_idx_r <= 8'd0;
                        rd_addr_r <= SRC_BASE;
                    end
                end
                ST_WAIT: pix_r <= main_ram_out;
                ST_W3: begin
                    if (last_s) begin
                        finished_r <= 1'b1;
                        rd_addr_r  <= SRC_BASE;
                    end else begin
                        src_idx_r <= src_idx_r + 8'd1;
                        rd_addr_r <= SRC_BASE + {4'b0000, src_idx_r + 8'd1};
                    end
                end
                default: ;
            endcase
        end
    end

    // Framebuffer port decoded from registers only; address is {y, k, x, j}.
    always_comb begin
        fb_write_enable  = 1'b0;
        fb_write_address = 10'd0;
        fb_ram_in        = 8'd0;
        case (state_r)
            ST_W0: begin
                fb_write_enable  = 1'b1;
                fb_write_address = {y_s, 1'b0, x_s, 1'b0};
                fb_ram_in        = hi_s;
            end
            ST_W1: begin
                fb_write_enable  = 1'b1;
                fb_write_address = {y_s, 1'b0, x_s, 1'b1};
                fb_ram_in        = lo_s;
            end
            ST_W2: begin
                fb_write_enable  = 1'b1;
                fb_write_address = {y_s, 1'b1, x_s, 1'b0};
                fb_ram_in        = hi_s;
            end
            ST_W3: begin
                fb_write_enable  = 1'b1;
                fb_write_address = {y_s, 1'b1, x_s, 1'b1};
                fb_ram_in        = lo_s;
            end
            default: begin
                fb_write_enable  = 1'b0;
                fb_write_address = 10'd0;
                fb_ram_in        = 8'd0;
            end
        endcase
    end

    assign busy                  = (state_r != ST_IDLE);
    assign finished_signal       = finished_r;
    assign main_ram_read_address = rd_addr_r;

endmodule

// File: tb/tb_chip8_fb_renderer.sv
// Directed bench for chip8_fb_renderer with a registered main-RAM model
// and a framebuffer scoreboard.
module tb_chip8_fb_renderer;

    logic        clk;
    logic        reset;
    logic        start_signal;
    logic [11:0] main_ram_read_address;
    logic [7:0]  main_ram_out;
    logic [9:0]  fb_write_address;
    logic        fb_write_enable;
    logic [7:0]  fb_ram_in;
    logic        busy;
    logic        finished_signal;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  ram [0:255];
    logic [7:0]  fb  [0:1023];
    int          hits[0:1023];
    int          wcount;

    logic [11:0] ra_log [0:1600];
    logic        we_log [0:1600];
    logic [9:0]  wa_log [0:1600];
    logic [7:0]  wd_log [0:1600];
    logic        bz_log [0:1600];

    int busy_n, fin_cyc, fin_n;

    chip8_fb_renderer dut (
        .clk                   (clk),
        .reset                 (reset),
        .start_signal          (start_signal),
        .main_ram_read_address (main_ram_read_address),
        .main_ram_out          (main_ram_out),
        .fb_write_address      (fb_write_address),
        .fb_write_enable       (fb_write_enable),
        .fb_ram_in             (fb_ram_in),
        .busy                  (busy),
        .finished_signal       (finished_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered main RAM: only the display page holds data.
    always @(posedge clk) begin
        if (main_ram_read_address[11:8] == 4'hF) main_ram_out <= ram[main_ram_read_address[7:0]];
        else main_ram_out <= 8'h00;
    end

    // Framebuffer scoreboard.
    always @(negedge clk) begin
        if (fb_write_enable === 1'b1) begin
            fb[fb_write_address]   = fb_ram_in;
            hits[fb_write_address] = hits[fb_write_address] + 1;
            wcount = wcount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input logic [7:0] fill);
        for (int i = 0; i < 1024; i++) begin
            fb[i]   = fill;
            hits[i] = 0;
        end
        wcount = 0;
    endtask

    // Runs max_cyc cycles after start is sampled, logging outputs per cycle.
    task automatic run_frame(input int p1, input int p2, input int rst_at, input int max_cyc);
        busy_n = 0; fin_cyc = 0; fin_n = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            ra_log[c] = main_ram_read_address;
            we_log[c] = fb_write_enable;
            wa_log[c] = fb_write_address;
            wd_log[c] = fb_ram_in;
            bz_log[c] = busy;
            if (busy === 1'b1) busy_n++;
            if (finished_signal === 1'b1) begin
                fin_n++;
                if (fin_cyc == 0) fin_cyc = c;
            end
            start_signal = (c == p1) || (c == p2);
            reset        = !(c == rst_at);
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start_signal = 1'b1;
    endtask

    initial begin
        int bad_hits, bad_data, late_we;
        reset = 1'b0;
        start_signal = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        clear_model(8'hFF);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fin", 32'(finished_signal), 32'h0);
        check("rst_we", 32'(fb_write_enable), 32'h0);
        check("rst_wa", 32'(fb_write_address), 32'h0);
        check("rst_wd", 32'(fb_ram_in), 32'h0);
        check("rst_ra", 32'(main_ram_read_address), 32'hF00);
        reset = 1'b1;
        @(negedge clk);

        // Frame 1: all zero, ignored re-start at 500, restart in finished cycle.
        kick();
        run_frame(500, 1537, 0, 1537);
        check("f1_busy_cycles", 32'(busy_n), 32'd1536);
        check("f1_fin_cycle", 32'(fin_cyc), 32'd1537);
        check("f1_fin_count", 32'(fin_n), 32'd1);
        check("f1_writes", 32'(wcount), 32'd1024);
        bad_hits = 0; bad_data = 0;
        for (int i = 0; i < 1024; i++) begin
            if (hits[i] != 1) bad_hits++;
            if (fb[i] !== 8'h00) bad_data++;
        end
        check("f1_addr_cover", 32'(bad_hits), 32'd0);
        check("f1_data_zero", 32'(bad_data), 32'd0);
        check("f1_first_ra", 32'(ra_log[1]), 32'hF00);
        check("f1_last_ra", 32'(ra_log[1531]), 32'hFFF);

        // Frame 2 starts from the finished-cycle request with patterned bytes.
        ram[0] = 8'h80; ram[9] = 8'hA5; ram[255] = 8'h01;
        clear_model(8'hFF);
        run_frame(0, 0, 0, 1540);
        check("f2_busy_first", 32'(bz_log[1]), 32'h1);
        check("f2_busy_cycles", 32'(busy_n), 32'd1536);
        check("f2_fin_cycle", 32'(fin_cyc), 32'd1537);
        check("f2_writes", 32'(wcount), 32'd1024);
        check("f2_ra0", 32'(ra_log[1]), 32'hF00);
        check("fb000", 32'(fb[10'h000]), 32'hC0);
        check("fb010", 32'(fb[10'h010]), 32'hC0);
        check("fb001", 32'(fb[10'h001]), 32'h00);
        check("fb011", 32'(fb[10'h011]), 32'h00);
        check("fb3ee", 32'(fb[10'h3EE]), 32'h00);
        check("fb3ef", 32'(fb[10'h3EF]), 32'h03);
        check("fb3fe", 32'(fb[10'h3FE]), 32'h00);
        check("fb3ff", 32'(fb[10'h3FF]), 32'h03);
        check("f2_ra255", 32'(ra_log[1531]), 32'hFFF);
        check("idx9_ra", 32'(ra_log[55]), 32'hF09);
        check("idx9_we_before", 32'(we_log[56]), 32'h0);
        check("idx9_w0", {we_log[57], 13'd0, wa_log[57], wd_log[57]}, {1'b1, 13'd0, 10'h022, 8'hCC});
        check("idx9_w1", {we_log[58], 13'd0, wa_log[58], wd_log[58]}, {1'b1, 13'd0, 10'h023, 8'h33});
        check("idx9_w2", {we_log[59], 13'd0, wa_log[59], wd_log[59]}, {1'b1, 13'd0, 10'h032, 8'hCC});
        check("idx9_w3", {we_log[60], 13'd0, wa_log[60], wd_log[60]}, {1'b1, 13'd0, 10'h033, 8'h33});
        check("idx9_we_after", 32'(we_log[61]), 32'h0);

        // Frame 3: reset at cycle 700 aborts the frame.
        clear_model(8'hFF);
        kick();
        run_frame(0, 0, 700, 720);
        check("abort_busy_700", 32'(bz_log[700]), 32'h1);
        check("abort_busy_701", 32'(bz_log[701]), 32'h0);
        check("abort_ra_701", 32'(ra_log[701]), 32'hF00);
        check("abort_fin", 32'(fin_n), 32'd0);
        check("abort_writes", 32'(wcount), 32'd466);
        late_we = 0;
        for (int c = 701; c <= 720; c++) if (we_log[c] !== 1'b0) late_we++;
        check("abort_no_we", 32'(late_we), 32'd0);

        // Frame 4: full render after the abort.
        clear_model(8'hFF);
        kick();
        run_frame(0, 0, 0, 1540);
        check("f4_busy_cycles", 32'(busy_n), 32'd1536);
        check("f4_fin_cycle", 32'(fin_cyc), 32'd1537);
        check("f4_fin_count", 32'(fin_n), 32'd1);
        check("f4_writes", 32'(wcount), 32'd1024);
        bad_hits = 0;
        for (int i = 0; i < 1024; i++) if (hits[i] != 1) bad_hits++;
        check("f4_addr_cover", 32'(bad_hits), 32'd0);
        check("f4_fb023", 32'(fb[10'h023]), 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
